// File: rtl/exhaustive_stim_gen.sv
// Clocked, handshaked sweep of all 2^WIDTH vectors into a combinational gate-under-test.
// Define GRAY_ORDER_EN to drive vectors in reflected Gray order; index always counts in binary.
module exhaustive_stim_gen #(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ready,
  output logic [WIDTH-1:0] vec,
  output logic             vec_valid,
  output logic [WIDTH-1:0] index,
  output logic             last,
  output logic             busy,
  output logic             done
);

  // Handshake: a vector is accepted on a rising edge where vec_valid=1, the
  // dwell time is met and ready=1; ready before dwell is met is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};
  localparam logic [7:0]       DWELL_M1 = 8'(DWELL - 1);

  function automatic logic [WIDTH-1:0] map_f(input logic [WIDTH-1:0] i);
`ifdef GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             dwell_met;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    vec_d     = vec_q;
    valid_d   = valid_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    dwell_met = (cnt_q >= DWELL_M1);

    if (abort) begin
      state_d = IDLE;
      index_d = '0;
      vec_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            index_d = '0;
            vec_d   = map_f('0);
            valid_d = 1'b1;
            done_d  = 1'b0;
            cnt_d   = 8'd0;
          end
        end
        RUN: begin
          if (dwell_met && ready) begin
            cnt_d = 8'd0;
            // Terminal count ends the sweep explicitly instead of wrapping.
            if (index_q == LAST_IDX) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              index_d = index_q + WIDTH'(1);
              vec_d   = map_f(index_q + WIDTH'(1));
            end
          end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end

    last_d = valid_d && (index_d == LAST_IDX);
    busy_d = (state_d == RUN);
  end

  assign vec       = vec_q;
  assign vec_valid = valid_q;
  assign index     = index_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Bench for exhaustive_stim_gen: instance 0 uses DWELL=1, instance 1 uses DWELL=3.
// A sweep-level model is compared against both instances on every falling edge.
module tb_exhaustive_stim_gen;

  localparam int N = 16;

  logic       clk;
  logic       rst_n;
  logic       start [2];
  logic       abort [2];
  logic       ready [2];
  logic [3:0] vec [2];
  logic [3:0] index [2];
  logic       vec_valid [2];
  logic       last [2];
  logic       busy [2];
  logic       done [2];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  exhaustive_stim_gen #(.WIDTH(4), .DWELL(1)) u_dw1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .ready(ready[0]),
    .vec(vec[0]), .vec_valid(vec_valid[0]), .index(index[0]), .last(last[0]),
    .busy(busy[0]), .done(done[0])
  );

  exhaustive_stim_gen #(.WIDTH(4), .DWELL(3)) u_dw3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .ready(ready[1]),
    .vec(vec[1]), .vec_valid(vec_valid[1]), .index(index[1]), .last(last[1]),
    .busy(busy[1]), .done(done[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic int map_f(input int i);
`ifdef GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // sweep-level model: position in the sweep, cycles held, active/done flags
  int dw [2] = '{1, 3};
  int m_pos [2] = '{0, 0};
  int m_hold [2] = '{0, 0};
  bit m_act [2] = '{0, 0};
  bit m_done [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 0; m_done[k] = 0; m_pos[k] = 0; m_hold[k] = 0;
      end else if (abort[k]) begin
        m_act[k] = 0; m_done[k] = 0; m_pos[k] = 0; m_hold[k] = 0;
      end else if (!m_act[k]) begin
        if (start[k]) begin
          m_act[k] = 1; m_done[k] = 0; m_pos[k] = 0; m_hold[k] = 0;
        end
      end else if (ready[k] && (m_hold[k] + 1 >= dw[k])) begin
        if (m_pos[k] == N - 1) begin
          m_act[k] = 0; m_done[k] = 1;
        end else begin
          m_pos[k] = m_pos[k] + 1; m_hold[k] = 0;
        end
      end else begin
        m_hold[k] = m_hold[k] + 1;
      end
    end
  end

  // scoreboard: compare every instance against the model each falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("sb_vec",   k, 32'(vec[k]),   32'(map_f(m_pos[k])));
        chk("sb_index", k, 32'(index[k]), 32'(m_pos[k]));
        chk("sb_valid", k, 32'(vec_valid[k]), 32'(m_act[k]));
        chk("sb_last",  k, 32'(last[k]),  32'(m_act[k] && (m_pos[k] == N - 1)));
        chk("sb_busy",  k, 32'(busy[k]),  32'(m_act[k]));
        chk("sb_done",  k, 32'(done[k]),  32'(m_done[k]));
      end
    end
  end

  // driver tasks (all inputs change on falling edges)
  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_idx(input int k, input int v);
    int n = 0;
    while (index[k] !== 4'(v) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idx", k, 32'(index[k]), 32'(v));
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (done[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", k, 32'(done[k]), 32'd1);
  endtask

  task automatic chk_idle(input string name, input int k);
    chk(name, k, {vec_valid[k], busy[k], done[k], last[k], vec[k], index[k]}, 32'd0);
  endtask

  int seq [N];
  int cnt;
  int sweeps;
  bit mid;
  logic [3:0] prev;

  initial begin
`ifdef GRAY_ORDER_EN
    seq = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
`else
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk_idle("reset_outputs", 0);
    chk_idle("reset_outputs", 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset_idle", 0);

    // first sweep, DWELL=1, ready tied high
    pulse_start(0);
    prev = vec[0];
    for (int i = 0; i < N; i++) begin
      chk("s1_vec", 0, 32'(vec[0]), 32'(seq[i]));
      chk("s1_index", 0, 32'(index[0]), 32'(i));
      chk("s1_last", 0, 32'(last[0]), 32'(i == N - 1));
      if (i > 0) chk("s1_hamming", 0, 32'($countones(vec[0] ^ prev)), 32'(seq[i] == i ? $countones(i ^ (i - 1)) : 1));
      prev = vec[0];
      @(negedge clk);
    end
    chk("s1_done", 0, 32'(done[0]), 32'd1);
    chk("s1_valid_low", 0, 32'(vec_valid[0]), 32'd0);
    chk("s1_vec_hold", 0, 32'(vec[0]), 32'(seq[N - 1]));

    // DWELL=3: every vector held exactly three cycles, then backpressure on index 5
    pulse_start(1);
    for (int i = 0; i < 15; i++) begin
      chk("dw_vec", 1, 32'(vec[1]), 32'(seq[i / 3]));
      @(negedge clk);
    end
    chk("dw_idx5", 1, 32'(index[1]), 32'd5);
    ready[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 1, 32'(vec[1]), 32'(seq[5]));
    end
    ready[1] = 1'b1;
    cnt = 0;
    while (index[1] !== 4'd6 && cnt < 3) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_resume", 1, 32'(index[1]), 32'd6);
    wait_done(1);

    // abort mid-sweep, then abort+start together from IDLE
    pulse_start(0);
    wait_idx(0, 7);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk_idle("abort_idle", 0);
    abort[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0; start[0] = 1'b0;
    chk_idle("abort_wins", 0);
    pulse_start(0);
    chk("restart_vec", 0, 32'(vec[0]), 32'd0);
    chk("restart_valid", 0, 32'(vec_valid[0]), 32'd1);
    wait_done(0);

    // asynchronous reset between clock edges
    pulse_start(0);
    wait_idx(0, 9);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 0);
    chk_idle("async_rst", 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("rst_release_idle", 0);
    end

    // ignored start in RUN, restart from DONE, two back-to-back sweeps
    pulse_start(0);
    cnt = 0; sweeps = 0; mid = 0;
    for (int n = 0; n < 200; n++) begin
      start[0] = 1'b0;
      if (vec_valid[0] === 1'b1) cnt++;
      if (vec_valid[0] === 1'b1 && index[0] === 4'd3 && !mid) begin
        start[0] = 1'b1;
        mid = 1;
      end
      if (done[0] === 1'b1) begin
        if (sweeps == 1) break;
        start[0] = 1'b1;
        sweeps++;
      end
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk("b2b_sweeps", 0, 32'(sweeps), 32'd1);
    chk("b2b_accepted", 0, 32'(cnt), 32'd32);
    chk("b2b_done", 0, 32'(done[0]), 32'd1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
